freelist_mp: RTL and testbench

FREELIST_MP -- requirements
Module: freelist_mp

---
 rtl/freelist_mp.sv | 113 +++++++++++
 tb/tb_freelist_mp.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/freelist_mp.sv
// freelist_mp: multi-lane physical register free list with branch checkpoints.
// Define FREELIST_MP_BYPASS_EN to let same-cycle frees satisfy allocations beyond count.
module freelist_mp #(
  parameter int LOG_REGS    = 32,
  parameter int PHY_REGS    = 64,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int NUM_CKPT    = 4,
  localparam int WIDTH = $clog2(PHY_REGS),
  localparam int DEPTH = PHY_REGS - LOG_REGS,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(NUM_CKPT)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ALLOC_PORTS-1:0]              alloc_req,
  output logic                                alloc_gnt,
  output logic [ALLOC_PORTS-1:0][WIDTH-1:0]   pd_alloc,
  input  logic [FREE_PORTS-1:0]               free_valid,
  input  logic [FREE_PORTS-1:0][WIDTH-1:0]    free_pd,
  input  logic                                ckpt_save,
  input  logic [CW-1:0]                       ckpt_id,
  input  logic                                restore_valid,
  input  logic [CW-1:0]                       restore_id,
  input  logic                                flush_all,
  output logic [AW:0]                         count,
  output logic                                empty,
  output logic                                full
);
  logic [WIDTH-1:0] fifo [DEPTH];
  logic [AW:0] ckpt [NUM_CKPT];
  logic [AW:0] head, tail, head_nx, tail_nx;
  logic [FREE_PORTS-1:0] legal, we;
  int woff [FREE_PORTS];
  int n, avail, n_st, nb, space, w, b;
`ifdef FREELIST_MP_BYPASS_EN
  int nl, j;
`endif
  function automatic logic [AW:0] ptr_add(input logic [AW:0] p, input int k);
    int idx = int'(p[AW-1:0]) + k;
    return idx >= DEPTH ? {~p[AW], AW'(idx - DEPTH)} : {p[AW], AW'(idx)};
  endfunction
  function automatic logic [AW-1:0] slot(input logic [AW:0] p, input int k);
    logic [AW:0] q = ptr_add(p, k);
    return q[AW-1:0];
  endfunction
  function automatic int ptr_diff(input logic [AW:0] a, input logic [AW:0] c);
    return int'(a[AW-1:0]) - int'(c[AW-1:0]) + (a[AW] != c[AW] ? DEPTH : 0);
  endfunction
  assign empty = count == '0;
  assign full  = count == (AW+1)'(DEPTH);
  always_comb begin
    n = 0;
    for (int i = 0; i < ALLOC_PORTS; i++) n += int'(alloc_req[i]);
    for (int i = 0; i < FREE_PORTS; i++) legal[i] = free_valid[i] && free_pd[i] != '0;
`ifdef FREELIST_MP_BYPASS_EN
    nl = 0;
    for (int i = 0; i < FREE_PORTS; i++) nl += int'(legal[i]);
    avail = int'(count) + nl;
`else
    avail = int'(count);
`endif
    alloc_gnt = rst && !flush_all && !restore_valid && n > 0 && avail >= n;
    n_st = alloc_gnt ? (n < int'(count) ? n : int'(count)) : 0;
    nb = alloc_gnt ? n - n_st : 0;
    head_nx = flush_all ? head : restore_valid ? ckpt[restore_id] : ptr_add(head, n_st);
    space = DEPTH - ptr_diff(tail, head_nx);
    // the first nb legal frees feed bypassed lanes; the rest compact onto the tail while room remains
    w = 0;
    b = 0;
    for (int i = 0; i < FREE_PORTS; i++) begin
      we[i] = 1'b0;
      woff[i] = 0;
      if (legal[i] && !flush_all) begin
        if (b < nb) b++;
        else if (w < space) begin
          we[i] = 1'b1;
          woff[i] = w;
          w++;
        end
      end
    end
    tail_nx = flush_all ? {~head[AW], head[AW-1:0]} : ptr_add(tail, w);
    for (int k = 0; k < ALLOC_PORTS; k++) pd_alloc[k] = fifo[slot(head, k)];
`ifdef FREELIST_MP_BYPASS_EN
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      j = 0;
      if (k >= int'(count))
        for (int i = 0; i < FREE_PORTS; i++)
          if (legal[i]) begin
            if (j == k - int'(count)) pd_alloc[k] = free_pd[i];
            j++;
          end
    end
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= {1'b1, {AW{1'b0}}};
      count <= (AW+1)'(DEPTH);
      for (int i = 0; i < DEPTH; i++) fifo[i] <= WIDTH'(LOG_REGS + i);
      for (int c = 0; c < NUM_CKPT; c++) ckpt[c] <= '0;
    end else begin
      head <= head_nx;
      tail <= tail_nx;
      count <= (AW+1)'(ptr_diff(tail_nx, head_nx));
      for (int i = 0; i < FREE_PORTS; i++)
        if (we[i]) fifo[slot(tail, woff[i])] <= free_pd[i];
      if (ckpt_save && !flush_all && !restore_valid) ckpt[ckpt_id] <= head_nx;
    end
  end
endmodule

// File: tb/tb_freelist_mp.sv
// tb_freelist_mp: scoreboard bench for freelist_mp against an unbounded-pointer queue model.
module tb_freelist_mp;
  localparam int D = 32;
  logic clk = 0, rst = 0;
  logic [1:0] alloc_req, free_valid, ckpt_id, restore_id;
  logic [1:0][5:0] pd_alloc, free_pd;
  logic alloc_gnt, ckpt_save, restore_valid, flush_all, empty, full;
  logic [5:0] count;
  int n_pass = 0, n_chk = 0;
  int expq[$];
  int mem[D];
  int ck[4];
  int h, t;
  freelist_mp dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .pd_alloc(pd_alloc),
    .free_valid(free_valid), .free_pd(free_pd), .ckpt_save(ckpt_save), .ckpt_id(ckpt_id),
    .restore_valid(restore_valid), .restore_id(restore_id), .flush_all(flush_all),
    .count(count), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic model_reset();
    h = 0;
    t = D;
    for (int i = 0; i < D; i++) mem[i] = 32 + i;
    for (int i = 0; i < 4; i++) ck[i] = 0;
  endtask
  function automatic int pop();
    return expq.size() > 0 ? expq.pop_front() : -1;
  endfunction
  task automatic cyc(input logic [1:0] req, input logic [1:0] fv, input int f0, input int f1,
                     input bit cs = 0, input int cid = 0, input bit rv = 0, input int rid = 0,
                     input bit fl = 0);
    int n, cnt, avail, nst, nb, e;
    int lq[$];
    bit g;
    @(negedge clk);
    alloc_req = req;
    free_valid = fv;
    free_pd[0] = 6'(f0);
    free_pd[1] = 6'(f1);
    ckpt_save = cs;
    ckpt_id = 2'(cid);
    restore_valid = rv;
    restore_id = 2'(rid);
    flush_all = fl;
    n = int'(req[0]) + int'(req[1]);
    if (fv[0] && f0 != 0) lq.push_back(f0);
    if (fv[1] && f1 != 0) lq.push_back(f1);
    cnt = t - h;
    avail = cnt;
`ifdef FREELIST_MP_BYPASS_EN
    avail += lq.size();
`endif
    g = !fl && !rv && n > 0 && avail >= n;
    expq.push_back(int'(g));
    if (g) begin
      for (int k = 0; k < n; k++) expq.push_back(k < cnt ? mem[(h + k) % D] : lq[k - cnt]);
      nst = n < cnt ? n : cnt;
      nb = n - nst;
      h += nst;
      repeat (nb) void'(lq.pop_front());
    end
    if (fl) t = h + D;
    else begin
      if (rv) h = ck[rid];
      else if (cs) ck[cid] = h;
      foreach (lq[i])
        if (t - h < D) begin
          mem[t % D] = lq[i];
          t++;
        end else $display("note: overflowing free of pd %0d dropped", lq[i]);
    end
    expq.push_back(t - h);
    #3;
    chk("gnt", int'(alloc_gnt), pop());
    if (g) for (int k = 0; k < n; k++) chk($sformatf("pd%0d", k), int'(pd_alloc[k]), pop());
    @(posedge clk);
    #1;
    e = pop();
    chk("count", int'(count), e);
    chk("full", int'(full), int'(e == D));
    chk("empty", int'(empty), int'(e == 0));
  endtask
  initial begin
    alloc_req = 2'b11;
    free_valid = '0;
    free_pd = '0;
    ckpt_save = 0;
    ckpt_id = '0;
    restore_valid = 0;
    restore_id = '0;
    flush_all = 0;
    #12;
    chk("rst_count", int'(count), D);
    chk("rst_full", int'(full), 1);
    chk("rst_empty", int'(empty), 0);
    chk("rst_gnt", int'(alloc_gnt), 0);
    model_reset();
    @(negedge clk);
    alloc_req = '0;
    rst = 1;
    cyc(2'b11, 2'b00, 0, 0);
    cyc(2'b00, 2'b11, 17, 0);
    cyc(2'b11, 2'b00, 0, 0, 1, 2);
    repeat (3) cyc(2'b11, 2'b00, 0, 0);
    cyc(2'b11, 2'b01, 9, 0, 0, 0, 1, 2);
    chk("restore_head", h, 4);
    while (t - h > 1) cyc(t - h >= 3 ? 2'b11 : 2'b01, 2'b00, 0, 0);
    cyc(2'b11, 2'b00, 0, 0);
    cyc(2'b11, 2'b01, 5, 0);
    while (t - h > 0) cyc(2'b01, 2'b00, 0, 0);
    cyc(2'b11, 2'b00, 0, 0);
    cyc(2'b11, 2'b01, 7, 0, 1, 1, 0, 0, 1);
    cyc(2'b01, 2'b00, 0, 0);
    for (int i = 0; i < 40 && h % D != 31; i++) cyc(2'b01, 2'b01, 1 + i, 0);
    chk("wrap_head", h % D, 31);
    cyc(2'b11, 2'b00, 0, 0);
    cyc(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    cyc(2'b00, 2'b11, 3, 4);
    for (int i = 0; i < 300; i++) begin
      logic [1:0] rq;
      int rid;
      bit rv;
      rq = i % 3 == 0 ? 2'b00 : i % 3 == 1 ? 2'b01 : 2'b11;
      if ($urandom_range(1, 0) == 1) rq = 2'b11;
      rid = $urandom_range(3, 0);
      rv = $urandom_range(7, 0) == 0 && t - ck[rid] <= D;
      cyc(rq, 2'($urandom_range(3, 0)), $urandom_range(63, 0), $urandom_range(63, 0),
          $urandom_range(1, 0) == 1, $urandom_range(3, 0), rv, rid, $urandom_range(39, 0) == 0);
    end
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rst_count", int'(count), D);
    chk("mid_rst_full", int'(full), 1);
    model_reset();
    alloc_req = '0;
    free_valid = '0;
    ckpt_save = 0;
    restore_valid = 0;
    flush_all = 0;
    @(negedge clk);
    rst = 1;
    cyc(2'b11, 2'b00, 0, 0);
    cyc(2'b11, 2'b00, 0, 0, 0, 0, 1, 2);
    chk("ckpt_cleared_head", h, 0);
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
